// File: rtl/merlin_arb_pkg.sv
// Shared constants for the Merlin instruction/data memory arbiter.
//   OWNER_I / OWNER_D : owner-FIFO encoding of which core port issued a request
//   SIZE_WORD         : access size driven for instruction fetches
package merlin_arb_pkg;

    localparam logic       OWNER_I   = 1'b0;
    localparam logic       OWNER_D   = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/merlin_arb_owner_fifo.sv
// In-order owner FIFO: one bit per in-flight target request, recording which
// port issued it so the matching response can be routed back.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, data_i      enqueue data_i (ignored when full)
//   pop_i               dequeue the head (ignored when empty)
//   full_o, empty_o     occupancy flags
//   head_o              oldest entry
module merlin_arb_owner_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    // One extra bit so a full FIFO is distinguishable from an empty one.
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/merlin_mem_arbiter.sv
// Two-requester memory arbiter: shares one single-ported target between the
// Merlin instruction port (i*) and data port (d*). Requests are multiplexed
// onto the target request channel (mreq*); an in-order owner FIFO steers each
// target response (mrsp*) back to the port that issued it.
// Ports:
//   clk_i, resetb_i     clock, asynchronous active-low reset
//   ireq*/irsp*         instruction port (word reads only)
//   dreq*/drsp*         data port
//   mreq*/mrsp*         target channel
//   spurious_o          sticky: a response arrived while nothing was in flight
// Configuration macro MERLIN_ARB_DATA_PRIORITY_EN: when defined the data port
// always wins a conflict; otherwise conflicts are resolved round-robin.
module merlin_mem_arbiter
    import merlin_arb_pkg::*;
#(
    parameter int unsigned C_ADDR_SZ     = 32,
    parameter int unsigned C_DATA_SZ     = 32,
    parameter int unsigned C_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 resetb_i,
    output logic                 ireqready_o,
    input  logic                 ireqvalid_i,
    input  logic [C_ADDR_SZ-1:0] ireqaddr_i,
    input  logic                 irspready_i,
    output logic                 irspvalid_o,
    output logic                 irsprerr_o,
    output logic [C_DATA_SZ-1:0] irspdata_o,
    output logic                 dreqready_o,
    input  logic                 dreqvalid_i,
    input  logic                 dreqwrite_i,
    input  logic [1:0]           dreqsize_i,
    input  logic [C_ADDR_SZ-1:0] dreqaddr_i,
    input  logic [C_DATA_SZ-1:0] dreqdata_i,
    input  logic                 drspready_i,
    output logic                 drspvalid_o,
    output logic                 drsperr_o,
    output logic [C_DATA_SZ-1:0] drspdata_o,
    input  logic                 mreqready_i,
    output logic                 mreqvalid_o,
    output logic                 mreqwrite_o,
    output logic [1:0]           mreqsize_o,
    output logic [C_ADDR_SZ-1:0] mreqaddr_o,
    output logic [C_DATA_SZ-1:0] mreqdata_o,
    output logic                 mrspready_o,
    input  logic                 mrspvalid_i,
    input  logic                 mrsperr_i,
    input  logic [C_DATA_SZ-1:0] mrspdata_i,
    output logic                 spurious_o
);

    logic grant;
    logic grant_valid;
    logic req_hs;
    logic rsp_pop;
    logic fifo_full, fifo_empty, fifo_head;
    logic lock_q, lock_d;
    logic lock_owner_q, lock_owner_d;
    logic spurious_q, spurious_d;
`ifndef MERLIN_ARB_DATA_PRIORITY_EN
    logic last_grant_q, last_grant_d;
`endif

    // Grant depends only on valids and registered state, never on mreqready_i.
    always_comb begin
        grant = OWNER_I;
        if (lock_q) begin
            grant = lock_owner_q;
        end else if (ireqvalid_i && dreqvalid_i) begin
`ifdef MERLIN_ARB_DATA_PRIORITY_EN
            grant = OWNER_D;
`else
            grant = ~last_grant_q;
`endif
        end else if (dreqvalid_i) begin
            grant = OWNER_D;
        end
        grant_valid = (grant == OWNER_D) ? dreqvalid_i : ireqvalid_i;
    end

    // Valid/ready outputs are forced low while reset is asserted.
    assign mreqvalid_o = resetb_i & grant_valid & ~fifo_full;
    assign ireqready_o = resetb_i & (grant == OWNER_I) & mreqready_i & ~fifo_full;
    assign dreqready_o = resetb_i & (grant == OWNER_D) & mreqready_i & ~fifo_full;
    assign req_hs      = mreqvalid_o & mreqready_i;

    always_comb begin
        if (grant == OWNER_D) begin
            mreqwrite_o = dreqwrite_i;
            mreqsize_o  = dreqsize_i;
            mreqaddr_o  = dreqaddr_i;
            mreqdata_o  = dreqdata_i;
        end else begin
            mreqwrite_o = 1'b0;
            mreqsize_o  = SIZE_WORD;
            mreqaddr_o  = ireqaddr_i;
            mreqdata_o  = '0;
        end
    end

    // Response routing by FIFO head; an ownerless beat is accepted and dropped.
    always_comb begin
        irspvalid_o = 1'b0;
        drspvalid_o = 1'b0;
        mrspready_o = 1'b0;
        if (resetb_i) begin
            if (fifo_empty) begin
                mrspready_o = 1'b1;
            end else if (fifo_head == OWNER_D) begin
                drspvalid_o = mrspvalid_i;
                mrspready_o = drspready_i;
            end else begin
                irspvalid_o = mrspvalid_i;
                mrspready_o = irspready_i;
            end
        end
    end

    assign irsprerr_o = mrsperr_i;
    assign irspdata_o = mrspdata_i;
    assign drsperr_o  = mrsperr_i;
    assign drspdata_o = mrspdata_i;
    assign rsp_pop    = mrspvalid_i & mrspready_o & ~fifo_empty;
    assign spurious_o = spurious_q;

    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        spurious_d   = spurious_q | (mrspvalid_i & fifo_empty);
        if (req_hs) begin
            lock_d = 1'b0;
        end else if (mreqvalid_o) begin
            // Stalled offer: hold this grant until the target takes it.
            lock_d       = 1'b1;
            lock_owner_d = grant;
        end
`ifndef MERLIN_ARB_DATA_PRIORITY_EN
        last_grant_d = req_hs ? grant : last_grant_q;
`endif
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_I;
            spurious_q   <= 1'b0;
`ifndef MERLIN_ARB_DATA_PRIORITY_EN
            last_grant_q <= OWNER_D;
`endif
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            spurious_q   <= spurious_d;
`ifndef MERLIN_ARB_DATA_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    merlin_arb_owner_fifo #(
        .Depth (C_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (resetb_i),
        .push_i  (req_hs),
        .data_i  (grant),
        .pop_i   (rsp_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_merlin_mem_arbiter.sv
module tb_merlin_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned OUT = 2;

    logic          clk = 1'b0;
    logic          resetb;
    logic          ireqready, ireqvalid, irspready, irspvalid, irsprerr;
    logic [AW-1:0] ireqaddr;
    logic [DW-1:0] irspdata;
    logic          dreqready, dreqvalid, dreqwrite, drspready, drspvalid, drsperr;
    logic [1:0]    dreqsize;
    logic [AW-1:0] dreqaddr;
    logic [DW-1:0] dreqdata, drspdata;
    logic          mreqready, mreqvalid, mreqwrite, mrspready, mrspvalid, mrsperr;
    logic [1:0]    mreqsize;
    logic [AW-1:0] mreqaddr;
    logic [DW-1:0] mreqdata, mrspdata;
    logic          spurious;

    merlin_mem_arbiter #(
        .C_ADDR_SZ     (AW),
        .C_DATA_SZ     (DW),
        .C_OUTSTANDING (OUT)
    ) dut (
        .clk_i       (clk),
        .resetb_i    (resetb),
        .ireqready_o (ireqready),
        .ireqvalid_i (ireqvalid),
        .ireqaddr_i  (ireqaddr),
        .irspready_i (irspready),
        .irspvalid_o (irspvalid),
        .irsprerr_o  (irsprerr),
        .irspdata_o  (irspdata),
        .dreqready_o (dreqready),
        .dreqvalid_i (dreqvalid),
        .dreqwrite_i (dreqwrite),
        .dreqsize_i  (dreqsize),
        .dreqaddr_i  (dreqaddr),
        .dreqdata_i  (dreqdata),
        .drspready_i (drspready),
        .drspvalid_o (drspvalid),
        .drsperr_o   (drsperr),
        .drspdata_o  (drspdata),
        .mreqready_i (mreqready),
        .mreqvalid_o (mreqvalid),
        .mreqwrite_o (mreqwrite),
        .mreqsize_o  (mreqsize),
        .mreqaddr_o  (mreqaddr),
        .mreqdata_o  (mreqdata),
        .mrspready_o (mrspready),
        .mrspvalid_i (mrspvalid),
        .mrsperr_i   (mrsperr),
        .mrspdata_i  (mrspdata),
        .spurious_o  (spurious)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of owners for in-flight requests (0 = I, 1 = D).
    bit owners[$];
    bit m_locked;
    bit m_lock_owner;
    bit m_last;
    bit m_spur;

    function automatic void model_reset();
        owners.delete();
        m_locked     = 0;
        m_lock_owner = 0;
        m_last       = 1;
        m_spur       = 0;
    endfunction

    task automatic model_cycle();
        bit g, gv, full, mv, exp_mrdy, head;
        if (!resetb) begin
            chk("rst_mreqvalid", mreqvalid, 0);
            chk("rst_ireqready", ireqready, 0);
            chk("rst_dreqready", dreqready, 0);
            chk("rst_irspvalid", irspvalid, 0);
            chk("rst_drspvalid", drspvalid, 0);
            chk("rst_mrspready", mrspready, 0);
            chk("rst_spurious", spurious, 0);
            model_reset();
            return;
        end
        if (m_locked) g = m_lock_owner;
        else if (ireqvalid && dreqvalid) begin
`ifdef MERLIN_ARB_DATA_PRIORITY_EN
            g = 1;
`else
            g = (m_last == 1) ? 0 : 1;
`endif
        end else g = dreqvalid;
        gv   = g ? dreqvalid : ireqvalid;
        full = (owners.size() >= OUT);
        mv   = gv && !full;
        chk("m_mreqvalid", mreqvalid, mv);
        if (ireqvalid || dreqvalid || m_locked) begin
            chk("m_ireqready", ireqready, (!g) && mreqready && !full);
            chk("m_dreqready", dreqready, g && mreqready && !full);
        end
        if (mv) begin
            chk("m_mreqaddr", mreqaddr, g ? dreqaddr : ireqaddr);
            chk("m_mreqwrite", mreqwrite, g ? dreqwrite : 1'b0);
            chk("m_mreqsize", mreqsize, g ? dreqsize : 2'b10);
            chk("m_mreqdata", mreqdata, g ? dreqdata : '0);
        end
        chk("m_spurious", spurious, m_spur);
        if (owners.size() == 0) begin
            exp_mrdy = 1;
            chk("m_mrspready_empty", mrspready, 1);
            chk("m_irspvalid_empty", irspvalid, 0);
            chk("m_drspvalid_empty", drspvalid, 0);
            if (mrspvalid) m_spur = 1;
        end else begin
            head     = owners[0];
            exp_mrdy = head ? drspready : irspready;
            chk("m_mrspready", mrspready, exp_mrdy);
            chk("m_irspvalid", irspvalid, !head && mrspvalid);
            chk("m_drspvalid", drspvalid, head && mrspvalid);
            if (mrspvalid && !head) begin
                chk("m_irspdata", irspdata, mrspdata);
                chk("m_irsprerr", irsprerr, mrsperr);
            end
            if (mrspvalid && head) begin
                chk("m_drspdata", drspdata, mrspdata);
                chk("m_drsperr", drsperr, mrsperr);
            end
            if (mrspvalid && exp_mrdy) void'(owners.pop_front());
        end
        if (mv && mreqready) begin
            owners.push_back(g);
            m_last   = g;
            m_locked = 0;
        end else if (mv) begin
            m_locked     = 1;
            m_lock_owner = g;
        end
    endtask

    // Model check at negedge, then return at posedge + 1 for the next drive.
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ireqvalid = 0; ireqaddr = '0; irspready = 0;
        dreqvalid = 0; dreqwrite = 0; dreqsize = 2'b10; dreqaddr = '0; dreqdata = '0;
        drspready = 0; mreqready = 0; mrspvalid = 0; mrsperr = 0; mrspdata = '0;
    endtask

    logic [AW-1:0] conflict_addr [4];

    initial begin
`ifdef MERLIN_ARB_DATA_PRIORITY_EN
        conflict_addr = '{32'h200, 32'h200, 32'h200, 32'h200};
`else
        conflict_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
`endif
        model_reset();
        idle();
        resetb = 0;
        ireqvalid = 1; mrspvalid = 1; mreqready = 1;
        #2;
        chk("reset_mreqvalid", mreqvalid, 0);
        chk("reset_ireqready", ireqready, 0);
        chk("reset_mrspready", mrspready, 0);
        chk("reset_spurious", spurious, 0);
        step();
        idle();
        resetb = 1;
        step();

        // I-only fetch and its response
        ireqvalid = 1; ireqaddr = 32'h0; mreqready = 1;
        #2;
        chk("ionly_mreqvalid", mreqvalid, 1);
        chk("ionly_mreqaddr", mreqaddr, 0);
        chk("ionly_mreqsize", mreqsize, 2'b10);
        chk("ionly_mreqwrite", mreqwrite, 0);
        chk("ionly_ireqready", ireqready, 1);
        step();
        ireqvalid = 0;
        mrspvalid = 1; mrspdata = 32'h0000_0013; irspready = 1;
        #2;
        chk("ionly_irspvalid", irspvalid, 1);
        chk("ionly_irspdata", irspdata, 32'h13);
        chk("ionly_drspvalid", drspvalid, 0);
        step();
        idle();

        // Fresh reset so the first conflict goes to I
        resetb = 0;
        step();
        resetb = 1;
        step();

        // Conflict with both ports requesting every cycle
        ireqvalid = 1; ireqaddr = 32'h100; dreqvalid = 1; dreqaddr = 32'h200;
        mreqready = 1; irspready = 1; drspready = 1; mrspdata = 32'h55;
        for (int k = 0; k < 4; k++) begin
            mrspvalid = (k > 0);
            #2;
            chk($sformatf("conflict_grant%0d", k), mreqaddr, conflict_addr[k]);
            step();
        end
        ireqvalid = 0; dreqvalid = 0; mrspvalid = 1;
        step();
        idle();

        // Lock: D offered while target stalls, I arrives meanwhile
        dreqvalid = 1; dreqwrite = 1; dreqsize = 2'b01; dreqaddr = 32'h300;
        dreqdata = 32'hdead_beef; mreqready = 0;
        #2;
        chk("lock_mreqvalid", mreqvalid, 1);
        chk("lock_mreqaddr0", mreqaddr, 32'h300);
        step();
        ireqvalid = 1; ireqaddr = 32'h400;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk($sformatf("lock_hold_addr%0d", k), mreqaddr, 32'h300);
            chk($sformatf("lock_hold_write%0d", k), mreqwrite, 1);
            chk($sformatf("lock_ireqready%0d", k), ireqready, 0);
            step();
        end
        mreqready = 1;
        #2;
        chk("lock_accept_dreqready", dreqready, 1);
        chk("lock_accept_ireqready", ireqready, 0);
        chk("lock_accept_data", mreqdata, 32'hdead_beef);
        step();
        dreqvalid = 0;
        #2;
        chk("lock_then_i_ready", ireqready, 1);
        chk("lock_then_i_addr", mreqaddr, 32'h400);
        step();

        // FIFO full (holds D, I)
        ireqaddr = 32'h500; dreqvalid = 1; dreqwrite = 0; dreqsize = 2'b10;
        dreqaddr = 32'h600;
        #2;
        chk("full_mreqvalid", mreqvalid, 0);
        chk("full_ireqready", ireqready, 0);
        chk("full_dreqready", dreqready, 0);
        step();
        mrspvalid = 1; mrspdata = 32'h11; irspready = 1; drspready = 1;
        #2;
        chk("full_pop_drspvalid", drspvalid, 1);
        chk("full_pop_irspvalid", irspvalid, 0);
        chk("full_pop_mreqvalid", mreqvalid, 0);
        step();
        mrspvalid = 0;
        #2;
        chk("full_regrant_valid", mreqvalid, 1);
        chk("full_regrant_addr", mreqaddr, 32'h600);
        step();
        dreqvalid = 0;
        #2;
        chk("full_again_mreqvalid", mreqvalid, 0);
        step();
        ireqvalid = 0;

        // FIFO holds I then D: stall the I consumer, then route D with error
        mrspvalid = 1; mrspdata = 32'haaaa; irspready = 0; drspready = 1;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk($sformatf("stall_irspvalid%0d", k), irspvalid, 1);
            chk($sformatf("stall_mrspready%0d", k), mrspready, 0);
            chk($sformatf("stall_drspvalid%0d", k), drspvalid, 0);
            step();
        end
        irspready = 1;
        #2;
        chk("stall_release_mrspready", mrspready, 1);
        chk("stall_release_data", irspdata, 32'haaaa);
        step();
        mrspvalid = 1; mrsperr = 1; mrspdata = 32'hbbbb;
        #2;
        chk("derr_drspvalid", drspvalid, 1);
        chk("derr_drsperr", drsperr, 1);
        chk("derr_irspvalid", irspvalid, 0);
        step();
        mrspvalid = 0; mrsperr = 0;

        // Spurious response with empty FIFO
        mrspvalid = 1;
        #2;
        chk("spur_mrspready", mrspready, 1);
        chk("spur_irspvalid", irspvalid, 0);
        chk("spur_before", spurious, 0);
        step();
        mrspvalid = 0;
        #2;
        chk("spur_sticky", spurious, 1);
        step();

        // Asynchronous reset in the middle of traffic
        ireqvalid = 1; ireqaddr = 32'h700; mreqready = 1;
        step();
        dreqvalid = 1; mrspvalid = 1; irspready = 0;
        #2;
        resetb = 0;
        #1;
        chk("arst_mreqvalid", mreqvalid, 0);
        chk("arst_ireqready", ireqready, 0);
        chk("arst_dreqready", dreqready, 0);
        chk("arst_irspvalid", irspvalid, 0);
        chk("arst_mrspready", mrspready, 0);
        chk("arst_spurious", spurious, 0);
        step();
        resetb = 1; ireqvalid = 0; dreqvalid = 0; mrspvalid = 1;
        #2;
        chk("arst_fifo_empty_mrspready", mrspready, 1);
        chk("arst_fifo_empty_irspvalid", irspvalid, 0);
        step();
        mrspvalid = 0;
        #2;
        chk("arst_spur_after", spurious, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
